uart_cmd_decoder: RTL and testbench

Byte-stream command decoder that sits directly downstream of the UART byte receiver. It consumes `data_byte` and the one-cycle `Rx_Done` strobe, assembles fixed-length 5-byte command frames, and verifies an 8-bit additive checksum. It emits a single-cycle register-write strobe with address and 16-bit data. An inter-byte timeout recovers from truncated frames, and a saturating error counter records bad frames for debug readout.

---
 rtl/uart_cmd_decoder.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 5-byte command frames (HEADER, ADDR, DATA_H,
// DATA_L, CHK) from the UART byte stream, verifies the 8-bit additive
// checksum, issues a register-write strobe, and flags checksum and
// inter-byte timeout errors with a saturating error count.
module uart_cmd_decoder #(
    parameter logic [7:0]      HEADER  = 8'h55,
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'd200000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  data_byte,
    input  logic        Rx_Done,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATH,
        S_DATL,
        S_CHK
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_TO  = 2'd2;

    state_t          state, state_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [7:0]      addr_q, addr_n;
    logic [7:0]      dath_q, dath_n;
    logic [7:0]      datl_q, datl_n;
    logic [7:0]      sum_q, sum_n;
    logic            wr_en_n;
    logic [7:0]      wr_addr_n;
    logic [15:0]     wr_data_n;
    logic            frame_err_n;
    logic [1:0]      err_code_n;
    logic [7:0]      err_cnt_n;
    logic            err_hit;
    logic            to_hit;

    // State, frame assembly registers and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            addr_q    <= '0;
            dath_q    <= '0;
            datl_q    <= '0;
            sum_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            to_cnt    <= to_cnt_n;
            addr_q    <= addr_n;
            dath_q    <= dath_n;
            datl_q    <= datl_n;
            sum_q     <= sum_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            frame_err <= frame_err_n;
            err_code  <= err_code_n;
            err_cnt   <= err_cnt_n;
        end
    end

    // Next-state, checksum accumulation, timeout and error bookkeeping
    always_comb begin
        state_n     = state;
        to_cnt_n    = to_cnt;
        addr_n      = addr_q;
        dath_n      = dath_q;
        datl_n      = datl_q;
        sum_n       = sum_q;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        frame_err_n = 1'b0;
        err_code_n  = err_code;
        err_cnt_n   = err_cnt;
        err_hit     = 1'b0;

        to_hit = (state != S_IDLE) && (to_cnt == TO_LAST);

        if (state == S_IDLE || Rx_Done) begin
            to_cnt_n = '0;
        end else begin
            to_cnt_n = to_cnt + 1'b1;
        end

        // A byte arriving on the terminal count is processed, not timed out
        if (Rx_Done) begin
            case (state)
                S_IDLE: begin
                    if (data_byte == HEADER) begin
                        state_n = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_n  = data_byte;
                    sum_n   = data_byte;
                    state_n = S_DATH;
                end
                S_DATH: begin
                    dath_n  = data_byte;
                    sum_n   = sum_q + data_byte;
                    state_n = S_DATL;
                end
                S_DATL: begin
                    datl_n  = data_byte;
                    sum_n   = sum_q + data_byte;
                    state_n = S_CHK;
                end
                S_CHK: begin
                    if (data_byte == sum_q) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr_q;
                        wr_data_n = {dath_q, datl_q};
                    end else begin
                        err_hit    = 1'b1;
                        err_code_n = ERR_CHK;
                    end
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (to_hit) begin
            err_hit    = 1'b1;
            err_code_n = ERR_TO;
            state_n    = S_IDLE;
        end

        if (err_hit) begin
            frame_err_n = 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt_n = err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed byte streams with a scoreboard queue
// of expected write/error events, checked by an independent output monitor.
module tb_uart_cmd_decoder;

    localparam logic [19:0] TO_VAL = 20'd100;

    logic        Clk;
    logic        Rst_n;
    logic [7:0]  data_byte;
    logic        Rx_Done;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    uart_cmd_decoder #(
        .HEADER  (8'h55),
        .TO_W    (20),
        .TIMEOUT (TO_VAL)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .data_byte (data_byte),
        .Rx_Done   (Rx_Done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every output strobe consumes one scoreboard entry
    always @(negedge Clk) begin
        if (Rst_n && (wr_en || frame_err)) begin
            exp_t e;
            check("strobe_exclusive", {31'd0, wr_en & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, wr_en, frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_en",     {31'd0, wr_en},     {31'd0, e.is_wr});
                check("frame_err", {31'd0, frame_err}, {31'd0, !e.is_wr});
                check("wr_addr",   {24'd0, wr_addr},   {24'd0, e.addr});
                check("wr_data",   {16'd0, wr_data},   {16'd0, e.data});
                check("err_code",  {30'd0, err_code},  {30'd0, e.code});
                check("err_cnt",   {24'd0, err_cnt},   {24'd0, e.cnt});
                if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        m_addr = a;
        m_data = d;
        e = '{is_wr: 1'b1, addr: a, data: d, code: m_code, cnt: m_cnt, cyc: -1};
        sb.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] code, input int at_cyc);
        exp_t e;
        m_code = code;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e = '{is_wr: 1'b0, addr: m_addr, data: m_data, code: code, cnt: m_cnt, cyc: at_cyc};
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        data_byte = b;
        Rx_Done   = 1'b1;
        @(negedge Clk);
        Rx_Done   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        send(8'h55);
        send(a);
        send(dh);
        send(dl);
        send(ck);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en",     {31'd0, wr_en},     32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_wr_addr",   {24'd0, wr_addr},   32'd0);
        check("rst_wr_data",   {16'd0, wr_data},   32'd0);
        check("rst_err_code",  {30'd0, err_code},  32'd0);
        check("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    endtask

    initial begin
        Rst_n     = 1'b0;
        Rx_Done   = 1'b0;
        data_byte = 8'h00;
        m_addr    = 8'h00;
        m_data    = 16'h0000;
        m_code    = 2'd0;
        m_cnt     = 8'd0;
        idle(3);
        check_reset_outputs();
        Rst_n = 1'b1;
        idle(2);

        // Valid frame: 12+AB+CD = 18A -> 8A
        expect_wr(8'h12, 16'hABCD);
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h8A);

        // Bad checksum, outputs keep 12/ABCD
        expect_err(2'd1, -1);
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h8B);

        // Garbage dropped silently, then frame 01/0002 (01+00+02 = 03)
        send(8'h00);
        send(8'hFF);
        expect_wr(8'h01, 16'h0002);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);

        // Timeout: strobe visible exactly TIMEOUT cycles after the last byte
        send(8'h55);
        send(8'h12);
        expect_err(2'd2, cyc + int'(TO_VAL));
        idle(150);
        expect_wr(8'h01, 16'h0002);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);

        // HEADER as data: 55+55+55 = FF, so 0F is a checksum error and FF is valid
        expect_err(2'd1, -1);
        send_frame(8'h55, 8'h55, 8'h55, 8'h0F);
        expect_wr(8'h55, 16'h5555);
        send_frame(8'h55, 8'h55, 8'h55, 8'hFF);

        // Each byte lands on the timeout terminal count: accepted, no error
        send(8'h55);
        idle(int'(TO_VAL) - 1);
        send(8'h01);
        idle(int'(TO_VAL) - 1);
        send(8'h00);
        idle(int'(TO_VAL) - 1);
        send(8'h02);
        idle(int'(TO_VAL) - 1);
        expect_wr(8'h01, 16'h0002);
        send(8'h03);

        // One cycle later than the terminal count times out; late byte lands in IDLE
        send(8'h55);
        expect_err(2'd2, cyc + int'(TO_VAL));
        idle(int'(TO_VAL));
        send(8'h12);
        idle(3);

        // Saturation: 260 bad frames (00+00+00 = 00, so 01 is wrong)
        for (int i = 0; i < 260; i++) begin
            expect_err(2'd1, -1);
            send_frame(8'h00, 8'h00, 8'h00, 8'h01);
        end
        idle(2);
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

        // Reset mid-frame, then a clean frame
        send(8'h55);
        send(8'h12);
        Rst_n = 1'b0;
        idle(2);
        check_reset_outputs();
        Rst_n  = 1'b1;
        m_addr = 8'h00;
        m_data = 16'h0000;
        m_code = 2'd0;
        m_cnt  = 8'd0;
        idle(2);
        expect_wr(8'h12, 16'hABCD);
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h8A);

        idle(5);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
